icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: LINE_NUM, default 32, number of direct-mapped lines (power of two).
REQ-002 Parameter: WORDS_PER_LINE, default 4, 32-bit words per line (power of two, >=2).
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: rdy  input  1  global ready; when low all state holds.
REQ-006 Port: icache_enable  input  1  fetcher requests the instruction at pc_to_icache.
REQ-007 Port: pc_to_icache  input  32  fetch address, word aligned.
REQ-008 Port: icache_valid  output  1  icache_inst holds the instruction for pc_to_icache this cycle.
REQ-009 Port: icache_inst  output  32  instruction word.
REQ-010 Port: mem_req  output  1  refill read request to memory controller.
REQ-011 Port: mem_addr  output  32  word address of current refill beat.
REQ-012 Port: mem_valid  input  1  mem_data carries the requested word.
REQ-013 Port: mem_data  input  32  returned word.
REQ-014 Port: ROB_jump_flag  input  1  pipeline redirect.

Function
REQ-015 Address split: offset = pc[1:0] (ignored), word = next log2(WORDS_PER_LINE) bits, index = next log2(LINE_NUM) bits, tag = remaining upper bits.
REQ-016 Hit = valid[index] && tag_array[index] == tag; combinational, zero latency.
REQ-017 icache_valid = icache_enable && hit && !ROB_jump_flag && rdy; icache_inst = data[index][word] whenever hit, else 0.
REQ-018 FSM states: IDLE, REFILL.
REQ-019 IDLE -> REFILL on icache_enable && !hit && rdy; latch line base address (pc with word and offset bits zeroed) and beat counter = 0; set valid[index] = 0.
REQ-020 In REFILL: mem_req = 1, mem_addr = line_base + 4*beat; each mem_valid cycle writes mem_data to data[index][beat] and increments beat.
REQ-021 On the beat WORDS_PER_LINE-1 accepted: write tag, set valid[index] = 1, return to IDLE; the line is hittable in the following cycle.
REQ-022 mem_req = 0 in IDLE; mem_addr holds last value.
REQ-023 In REFILL icache_valid is 0 regardless of pc (no hit-under-miss).
REQ-024 ROB_jump_flag during REFILL does not abort; refill completes (line data stays correct), then new pc evaluated from IDLE.
REQ-025 Miss with icache_enable dropped before refill starts: no refill launched.
REQ-026 rdy low: FSM, counter, arrays hold; mem_valid ignored; icache_valid 0.
REQ-027 Beat counter width log2(WORDS_PER_LINE); wraps to 0 only on completion.

Reset
REQ-028 On rst low, immediately: state = IDLE, beat = 0, all valid bits 0, mem_req 0, mem_addr 0; icache_valid 0.
REQ-029 Tag/data arrays not reset.
REQ-030 Reset mid-refill abandons the refill; line left invalid.

Structure
REQ-031 State encodings and True/False constants in the shared defines header.
REQ-032 Single module; tag/valid/data arrays as register arrays internal to it, no sub-module.

Verification
REQ-033 Cold miss pc=0x0: mem_req beats at 0x0,0x4,0x8,0xC; icache_valid=1 with word@0x0 one cycle after 4th mem_valid.
REQ-034 After REQ-033, pc=0x8: icache_valid=1 same cycle, no mem_req.
REQ-035 Conflict: pc=0x200 (same index 0, new tag) misses and refills; subsequent pc=0x0 misses again.
REQ-036 ROB_jump_flag=1 at beat 2 of refill: beats 2,3 still fetched, line valid afterward, icache_valid 0 during refill.
REQ-037 rst low at beat 1: mem_req drops immediately; pc of that line misses after reset.
REQ-038 rdy low for 3 cycles mid-refill with mem_valid pulsed: no beat consumed, counter unchanged.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared definitions for the direct-mapped instruction cache.
//   state_e     : refill FSM encoding (StIdle = idle/lookup, StRefill = line fill)
//   True, False : single-bit logic constants used by the cache datapath
package icache_pkg;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    typedef enum logic {
        StIdle   = 1'b0,
        StRefill = 1'b1
    } state_e;

endpackage

// File: rtl/icache.sv
// icache: direct-mapped instruction cache with a blocking, line-sized refill.
// Lookups complete in the same cycle. A miss fetches the whole line from memory,
// one word per beat, before the cache accepts another lookup.
//
// Ports:
//   clk            : clock; all state updates on the rising edge
//   rst            : asynchronous active-low reset
//   rdy            : global ready; when low, all state holds and mem_valid is ignored
//   icache_enable  : fetcher requests the instruction at pc_to_icache
//   pc_to_icache   : word-aligned fetch address
//   icache_valid   : icache_inst holds the instruction for pc_to_icache this cycle
//   icache_inst    : instruction word; zero when the lookup misses
//   mem_req        : refill read request, high for the whole refill
//   mem_addr       : word address of the current refill beat; holds its last value when idle
//   mem_valid      : mem_data carries the requested word
//   mem_data       : word returned by memory
//   ROB_jump_flag  : pipeline redirect; suppresses icache_valid but never aborts a refill
module icache
    import icache_pkg::*;
#(
    parameter int unsigned LINE_NUM       = 32,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        icache_enable,
    input  logic [31:0] pc_to_icache,
    output logic        icache_valid,
    output logic [31:0] icache_inst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data,
    input  logic        ROB_jump_flag
);

    localparam int unsigned WordW = $clog2(WORDS_PER_LINE);
    localparam int unsigned IdxW  = $clog2(LINE_NUM);
    localparam int unsigned IdxLo = WordW + 2;
    localparam int unsigned TagLo = IdxLo + IdxW;
    localparam int unsigned TagW  = 32 - TagLo;

    // Clears the word and byte-offset fields, leaving the line base address.
    localparam logic [31:0] LineMask = ~((32'd1 << IdxLo) - 32'd1);
    localparam logic [WordW-1:0] LastBeat = WordW'(WORDS_PER_LINE - 1);

    state_e              state_q, state_d;
    logic [WordW-1:0]    beat_q, beat_d;
    logic [31:0]         base_q, base_d;
    logic [31:0]         last_addr_q, last_addr_d;
    logic [LINE_NUM-1:0] valid_q, valid_d;

    logic [TagW-1:0]     tag_q  [LINE_NUM];
    logic [31:0]         data_q [LINE_NUM][WORDS_PER_LINE];

    logic [WordW-1:0]    pc_word;
    logic [IdxW-1:0]     pc_idx;
    logic [TagW-1:0]     pc_tag;
    logic [IdxW-1:0]     ref_idx;
    logic [TagW-1:0]     ref_tag;
    logic [31:0]         beat_addr;
    logic                hit;
    logic                fill_we;
    logic                fill_last;

    assign pc_word = pc_to_icache[IdxLo-1:2];
    assign pc_idx  = pc_to_icache[TagLo-1:IdxLo];
    assign pc_tag  = pc_to_icache[31:TagLo];

    // The line being filled is identified by the latched base, not the live pc,
    // so the fetcher may change pc freely during a refill.
    assign ref_idx   = base_q[TagLo-1:IdxLo];
    assign ref_tag   = base_q[31:TagLo];
    assign beat_addr = base_q + {{(30 - WordW){1'b0}}, beat_q, 2'b00};

    assign hit       = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign fill_we   = (state_q == StRefill) && rdy && mem_valid;
    assign fill_last = (beat_q == LastBeat);

    // No hit-under-miss: lookups are only answered from the idle state.
    assign icache_valid = icache_enable && hit && !ROB_jump_flag && rdy && (state_q == StIdle);
    assign icache_inst  = hit ? data_q[pc_idx][pc_word] : 32'd0;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        base_d      = base_q;
        last_addr_d = last_addr_q;
        valid_d     = valid_q;
        mem_req     = False;
        mem_addr    = last_addr_q;

        case (state_q)
            StIdle: begin
                if (rdy && icache_enable && !hit) begin
                    state_d         = StRefill;
                    base_d          = pc_to_icache & LineMask;
                    beat_d          = '0;
                    valid_d[pc_idx] = False;
                end
            end
            StRefill: begin
                mem_req  = True;
                mem_addr = beat_addr;
                if (rdy) begin
                    last_addr_d = beat_addr;
                    if (mem_valid) begin
                        if (fill_last) begin
                            beat_d           = '0;
                            valid_d[ref_idx] = True;
                            state_d          = StIdle;
                        end else begin
                            beat_d = beat_q + WordW'(1);
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            base_q      <= '0;
            last_addr_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            base_q      <= base_d;
            last_addr_q <= last_addr_d;
            valid_q     <= valid_d;
        end
    end

    // Tag and data storage carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[ref_idx][beat_q] <= mem_data;
            if (fill_last) begin
                tag_q[ref_idx] <= ref_tag;
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb_icache: self-checking bench for icache (LINE_NUM=32, WORDS_PER_LINE=4).
// Inputs change on the falling clock edge and outputs are sampled 1 ns later.
// Expected refill addresses and expected instruction words are queued when the
// stimulus is driven and popped when the cache presents them.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        icache_enable = 1'b0;
    logic [31:0] pc_to_icache = 32'd0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_data = 32'd0;
    logic        ROB_jump_flag = 1'b0;
    logic        icache_valid;
    logic [31:0] icache_inst;
    logic        mem_req;
    logic [31:0] mem_addr;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_inst_q [$];

    always #5 clk = ~clk;

    icache #(
        .LINE_NUM       (32),
        .WORDS_PER_LINE (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .icache_enable (icache_enable),
        .pc_to_icache  (pc_to_icache),
        .icache_valid  (icache_valid),
        .icache_inst   (icache_inst),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_valid     (mem_valid),
        .mem_data      (mem_data),
        .ROB_jump_flag (ROB_jump_flag)
    );

    // Memory contents: a fixed scramble of the address, distinct for every word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h1234};
    endfunction

    task automatic next_cycle();
        @(negedge clk);
        mem_valid = 1'b0;
    endtask

    task automatic push_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_addr_q.push_back(base + 32'(4 * i));
    endtask

    task automatic push_inst(input logic [31:0] pc);
        exp_inst_q.push_back(mem_word(pc));
    endtask

    // Serves refill beats first..last, one per cycle, checking each request.
    task automatic refill_beats(input int first, input int last);
        logic [31:0] a;
        for (int b = first; b <= last; b++) begin
            next_cycle();
            if (exp_addr_q.size() == 0) begin
                total++; bad++;
                $display("FAIL beat%0d: no expected address queued", b);
                a = 32'd0;
            end else begin
                a = exp_addr_q.pop_front();
            end
            mem_valid = 1'b1;
            mem_data  = mem_word(a);
            #1;
            total++;
            if (mem_req !== 1'b1 || mem_addr !== a || icache_valid !== 1'b0) begin
                bad++;
                $display("FAIL beat%0d: req=%b addr=%h ivalid=%b, want req=1 addr=%h ivalid=0",
                         b, mem_req, mem_addr, icache_valid, a);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] e;
        @(negedge clk);
        rdy = 1'b1; icache_enable = 1'b1; pc_to_icache = 32'h0;
        #1;
        total++;
        if (mem_req !== 1'b0) begin
            bad++; $display("FAIL reset_req: got %b want 0", mem_req);
        end
        total++;
        if (mem_addr !== 32'h0) begin
            bad++; $display("FAIL reset_addr: got %h want 00000000", mem_addr);
        end
        total++;
        if (icache_valid !== 1'b0) begin
            bad++; $display("FAIL reset_ivalid: got %b want 0", icache_valid);
        end
        next_cycle();
        #1;
        total++;
        if (mem_req !== 1'b0) begin
            bad++; $display("FAIL reset_hold_req: got %b want 0", mem_req);
        end
        next_cycle();
        rst = 1'b1; icache_enable = 1'b0;
        e = 32'h0;
        #1;
        total++;
        if (mem_addr !== e) begin
            bad++; $display("FAIL reset_release_addr: got %h want %h", mem_addr, e);
        end
    endtask

    task automatic test_cold_miss();
        logic [31:0] e;
        next_cycle();
        pc_to_icache = 32'h0; icache_enable = 1'b1;
        push_line(32'h0);
        #1;
        total++;
        if (icache_valid !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL cold_lookup: ivalid=%b req=%b, want 0 0", icache_valid, mem_req);
        end
        refill_beats(0, 3);
        next_cycle();
        push_inst(32'h0);
        #1;
        e = exp_inst_q.pop_front();
        total++;
        if (icache_valid !== 1'b1 || icache_inst !== e) begin
            bad++; $display("FAIL cold_fill_hit: valid=%b inst=%h, want 1 %h",
                            icache_valid, icache_inst, e);
        end
        total++;
        if (mem_req !== 1'b0 || mem_addr !== 32'hC) begin
            bad++; $display("FAIL cold_idle_bus: req=%b addr=%h, want 0 0000000c", mem_req, mem_addr);
        end
    endtask

    task automatic test_hit();
        logic [31:0] e;
        next_cycle();
        pc_to_icache = 32'h8;
        push_inst(32'h8);
        #1;
        e = exp_inst_q.pop_front();
        total++;
        if (icache_valid !== 1'b1 || icache_inst !== e || mem_req !== 1'b0) begin
            bad++; $display("FAIL hit_0x8: valid=%b inst=%h req=%b, want 1 %h 0",
                            icache_valid, icache_inst, mem_req, e);
        end
        next_cycle();
        #1;
        total++;
        if (mem_req !== 1'b0) begin
            bad++; $display("FAIL hit_no_refill: req=%b want 0", mem_req);
        end
        ROB_jump_flag = 1'b1;
        #1;
        total++;
        if (icache_valid !== 1'b0) begin
            bad++; $display("FAIL hit_jump_masks: ivalid=%b want 0", icache_valid);
        end
        ROB_jump_flag = 1'b0; icache_enable = 1'b0;
        #1;
        total++;
        if (icache_valid !== 1'b0 || icache_inst !== mem_word(32'h8)) begin
            bad++; $display("FAIL hit_disabled: valid=%b inst=%h, want 0 %h",
                            icache_valid, icache_inst, mem_word(32'h8));
        end
    endtask

    task automatic test_conflict();
        logic [31:0] e;
        next_cycle();
        pc_to_icache = 32'h200; icache_enable = 1'b1;
        push_line(32'h200);
        #1;
        total++;
        if (icache_valid !== 1'b0) begin
            bad++; $display("FAIL conflict_miss_200: ivalid=%b want 0", icache_valid);
        end
        refill_beats(0, 3);
        next_cycle();
        push_inst(32'h200);
        #1;
        e = exp_inst_q.pop_front();
        total++;
        if (icache_valid !== 1'b1 || icache_inst !== e) begin
            bad++; $display("FAIL conflict_hit_200: valid=%b inst=%h, want 1 %h",
                            icache_valid, icache_inst, e);
        end
        next_cycle();
        pc_to_icache = 32'h0;
        push_line(32'h0);
        #1;
        total++;
        if (icache_valid !== 1'b0) begin
            bad++; $display("FAIL conflict_evicted_0: ivalid=%b want 0", icache_valid);
        end
        refill_beats(0, 3);
        next_cycle();
        push_inst(32'h0);
        #1;
        e = exp_inst_q.pop_front();
        total++;
        if (icache_valid !== 1'b1 || icache_inst !== e) begin
            bad++; $display("FAIL conflict_rehit_0: valid=%b inst=%h, want 1 %h",
                            icache_valid, icache_inst, e);
        end
    endtask

    task automatic test_jump_during_refill();
        logic [31:0] e;
        next_cycle();
        pc_to_icache = 32'h40; icache_enable = 1'b1;
        push_line(32'h40);
        #1;
        total++;
        if (icache_valid !== 1'b0) begin
            bad++; $display("FAIL jump_miss_40: ivalid=%b want 0", icache_valid);
        end
        // Point at a cached line during the refill; it must not be answered.
        next_cycle();
        pc_to_icache = 32'h8;
        #1;
        total++;
        if (mem_req !== 1'b1 || icache_valid !== 1'b0) begin
            bad++; $display("FAIL jump_no_hum: req=%b ivalid=%b, want 1 0", mem_req, icache_valid);
        end
        refill_beats(0, 1);
        ROB_jump_flag = 1'b1;
        refill_beats(2, 3);
        next_cycle();
        ROB_jump_flag = 1'b0;
        pc_to_icache  = 32'h44;
        push_inst(32'h44);
        #1;
        e = exp_inst_q.pop_front();
        total++;
        if (icache_valid !== 1'b1 || icache_inst !== e || mem_req !== 1'b0) begin
            bad++; $display("FAIL jump_line_valid: valid=%b inst=%h req=%b, want 1 %h 0",
                            icache_valid, icache_inst, mem_req, e);
        end
    endtask

    task automatic test_rdy_stall();
        logic [31:0] e;
        next_cycle();
        pc_to_icache = 32'h80; icache_enable = 1'b1;
        push_line(32'h80);
        #1;
        refill_beats(0, 0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            rdy = 1'b0; mem_valid = 1'b1; mem_data = 32'hDEAD_BEEF; pc_to_icache = 32'h8;
            #1;
            total++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h84 || icache_valid !== 1'b0) begin
                bad++; $display("FAIL stall%0d: req=%b addr=%h ivalid=%b, want 1 00000084 0",
                                i, mem_req, mem_addr, icache_valid);
            end
        end
        next_cycle();
        rdy = 1'b1;
        #1;
        total++;
        if (mem_addr !== 32'h84) begin
            bad++; $display("FAIL stall_resume_addr: got %h want 00000084", mem_addr);
        end
        refill_beats(1, 3);
        next_cycle();
        pc_to_icache = 32'h84;
        push_inst(32'h84);
        #1;
        e = exp_inst_q.pop_front();
        total++;
        if (icache_valid !== 1'b1 || icache_inst !== e) begin
            bad++; $display("FAIL stall_data: valid=%b inst=%h, want 1 %h", icache_valid, icache_inst, e);
        end
        rdy = 1'b0;
        #1;
        total++;
        if (icache_valid !== 1'b0) begin
            bad++; $display("FAIL stall_idle_ivalid: got %b want 0", icache_valid);
        end
        rdy = 1'b1;
    endtask

    task automatic test_enable_drop();
        next_cycle();
        pc_to_icache = 32'hC0; icache_enable = 1'b1;
        #1;
        icache_enable = 1'b0;
        next_cycle();
        #1;
        total++;
        if (mem_req !== 1'b0) begin
            bad++; $display("FAIL enable_drop: req=%b want 0", mem_req);
        end
        icache_enable = 1'b1; rdy = 1'b0;
        next_cycle();
        #1;
        total++;
        if (mem_req !== 1'b0) begin
            bad++; $display("FAIL miss_rdy_low: req=%b want 0", mem_req);
        end
        icache_enable = 1'b0; rdy = 1'b1;
    endtask

    task automatic test_reset_mid_refill();
        next_cycle();
        pc_to_icache = 32'h100; icache_enable = 1'b1;
        push_line(32'h100);
        #1;
        refill_beats(0, 0);
        next_cycle();
        #1;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin
            bad++; $display("FAIL rstmid_beat1: req=%b addr=%h, want 1 00000104", mem_req, mem_addr);
        end
        rst = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            bad++; $display("FAIL rstmid_async: req=%b addr=%h, want 0 00000000", mem_req, mem_addr);
        end
        exp_addr_q.delete();
        next_cycle();
        rst = 1'b1;
        #1;
        total++;
        if (icache_valid !== 1'b0) begin
            bad++; $display("FAIL rstmid_line_invalid: ivalid=%b want 0", icache_valid);
        end
        pc_to_icache = 32'h8;
        #1;
        total++;
        if (icache_valid !== 1'b0) begin
            bad++; $display("FAIL rstmid_valid_cleared: ivalid=%b want 0", icache_valid);
        end
        icache_enable = 1'b0;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_jump_during_refill();
        test_rdy_stall();
        test_enable_drop();
        test_reset_mid_refill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
